// File: rtl/cram_backup_arbiter_if.sv
// Backup-engine request bus: word transfer request, completion pulse and read-back word.
// The requester uses the master modport and the arbiter uses the slave modport.
interface cram_backup_arbiter_if #(
    parameter int ADDR_W = 17
);
    logic              bk_req;
    logic              bk_wr;
    logic [ADDR_W-1:0] bk_addr;
    logic [15:0]       bk_din;
    logic [15:0]       bk_dout;
    logic              bk_ack;
    logic              busy;

    modport master (
        output bk_req, bk_wr, bk_addr, bk_din,
        input  bk_dout, bk_ack, busy
    );

    modport slave (
        input  bk_req, bk_wr, bk_addr, bk_din,
        output bk_dout, bk_ack, busy
    );
endinterface

// File: rtl/cram_backup_arbiter.sv
// Shares the single-port cart RAM between CPU accesses and 16-bit backup word transfers,
// which are split into two byte accesses placed in the gaps between CPU enable cycles.
//
// state | meaning
// IDLE  | waiting for a backup request (ignored while bk_ack is high)
// LO    | issue the even byte when the CPU leaves the port free
// HI    | issue the odd byte when the CPU leaves the port free
// DONE  | no RAM access; raise bk_ack for the following cycle
module cram_backup_arbiter #(
    parameter int ADDR_W = 17
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce_cpu,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_di,
    cram_backup_arbiter_if.slave bk,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_di,
    input  logic [7:0]        ram_do
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       din_q, din_d;
    logic              wr_q, wr_d;
    logic              ack_q, ack_d;
    logic [15:0]       dout_q, dout_d;
    logic              cap_lo_q, cap_lo_d;
    logic              cap_hi_q, cap_hi_d;
    logic              cpu_slot;

    always_comb begin
        cpu_slot = ce_cpu & cpu_req;
        state_d  = state_q;
        addr_d   = addr_q;
        din_d    = din_q;
        wr_d     = wr_q;
        ack_d    = 1'b0;
        cap_lo_d = 1'b0;
        cap_hi_d = 1'b0;
        dout_d   = dout_q;
        ram_addr = cpu_addr;
        ram_di   = cpu_di;
        ram_we   = cpu_slot & cpu_wr;

        // Capture uses the data returned for last cycle's issue, so a CPU slot now cannot disturb it.
        if (cap_lo_q) dout_d[7:0]  = ram_do;
        if (cap_hi_q) dout_d[15:8] = ram_do;

        case (state_q)
            ST_IDLE: begin
                if (!cpu_slot && bk.bk_req && !ack_q) begin
                    addr_d  = bk.bk_addr & ~ADDR_W'(1);
                    din_d   = bk.bk_din;
                    wr_d    = bk.bk_wr;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (!cpu_slot) begin
                    ram_addr = addr_q;
                    ram_di   = din_q[7:0];
                    ram_we   = wr_q;
                    cap_lo_d = ~wr_q;
                    state_d  = ST_HI;
                end
            end
            ST_HI: begin
                if (!cpu_slot) begin
                    ram_addr = addr_q | ADDR_W'(1);
                    ram_di   = din_q[15:8];
                    ram_we   = wr_q;
                    cap_hi_d = ~wr_q;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                ack_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            din_q    <= '0;
            wr_q     <= 1'b0;
            ack_q    <= 1'b0;
            dout_q   <= '0;
            cap_lo_q <= 1'b0;
            cap_hi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            wr_q     <= wr_d;
            ack_q    <= ack_d;
            dout_q   <= dout_d;
            cap_lo_q <= cap_lo_d;
            cap_hi_q <= cap_hi_d;
        end
    end

    assign bk.bk_ack  = ack_q;
    assign bk.bk_dout = dout_q;
    assign bk.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cram_backup_arbiter.sv
// Bench for cram_backup_arbiter: a byte-array reference model predicts every backup
// completion (cycle and read word); a monitor pops and compares on each bk_ack.
module tb_cram_backup_arbiter;
    localparam int ADDR_W = 17;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              ce_cpu, cpu_req, cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_di;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_di;
    logic [7:0]        ram_do;

    cram_backup_arbiter_if #(.ADDR_W(ADDR_W)) bk_if ();

    cram_backup_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ce_cpu   (ce_cpu),
        .cpu_req  (cpu_req),
        .cpu_wr   (cpu_wr),
        .cpu_addr (cpu_addr),
        .cpu_di   (cpu_di),
        .bk       (bk_if),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_di   (ram_di),
        .ram_do   (ram_do)
    );

    always #5 clk_sys = ~clk_sys;

    // Cart RAM macro: synchronous read with one cycle of latency.
    logic [7:0] mem    [0:131071];
    logic [7:0] shadow [0:131071];
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_di;
        ram_do <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          rd;
        logic [15:0] word;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [16:0] rand_addr();
        if ($urandom_range(0, 1) == 1) return 17'($urandom_range(0, 127));
        return 17'(17'h1FF80 + 17'($urandom_range(0, 127)));
    endfunction

    always @(negedge clk_sys) begin
        if (reset_n && bk_if.bk_ack) begin
            if (exp_q.size() == 0) begin
                chk("ack_unexpected", 32'(bk_if.bk_ack), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                if (e.rd) chk("read_word", 32'(bk_if.bk_dout), 32'(e.word));
            end
        end
    end

    task automatic set_cpu(input bit slot, input bit wr, input logic [16:0] a, input logic [7:0] d);
        if (slot) begin
            ce_cpu  = 1'b1;
            cpu_req = 1'b1;
        end else begin
            ce_cpu  = 1'($urandom_range(0, 1));
            cpu_req = ce_cpu ? 1'b0 : 1'($urandom_range(0, 1));
        end
        cpu_wr   = wr;
        cpu_addr = a;
        cpu_di   = d;
    endtask

    // One clock: drive CPU side, check the RAM port mid-cycle, return at posedge+1.
    task automatic step(input bit slot, input bit cwr, input logic [16:0] ca, input logic [7:0] cd,
                        input int iss, input bit iwr, input logic [16:0] ia, input logic [7:0] id);
        set_cpu(slot, cwr, ca, cd);
        @(negedge clk_sys);
        if (slot) begin
            chk("cpu_pass_addr", 32'(ram_addr), 32'(ca));
            chk("cpu_pass_we", 32'(ram_we), 32'(cwr));
            chk("cpu_pass_di", 32'(ram_di), 32'(cd));
        end else if (iss >= 0) begin
            chk(iss == 0 ? "bk_lo_addr" : "bk_hi_addr", 32'(ram_addr), 32'(ia));
            chk("bk_we", 32'(ram_we), 32'(iwr));
            if (iwr) chk("bk_di", 32'(ram_di), 32'(id));
        end else begin
            chk("quiet_we", 32'(ram_we), 32'd0);
            chk("quiet_addr", 32'(ram_addr), 32'(ca));
        end
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bit          slot, cwr;
            logic [16:0] ca;
            logic [7:0]  cd;
            bk_if.bk_req  = 1'b0;
            bk_if.bk_wr   = 1'($urandom_range(0, 1));
            bk_if.bk_addr = 17'($urandom);
            bk_if.bk_din  = 16'($urandom);
            slot = ($urandom_range(0, 2) == 0);
            cwr  = 1'($urandom_range(0, 1));
            ca   = rand_addr();
            cd   = 8'($urandom);
            if (slot && cwr) shadow[ca] = cd;
            step(slot, cwr, ca, cd, -1, 1'b0, 17'd0, 8'd0);
        end
    endtask

    task automatic cpu_write(input logic [16:0] a, input logic [7:0] d);
        bk_if.bk_req = 1'b0;
        shadow[a] = d;
        step(1'b1, 1'b1, a, d, -1, 1'b0, 17'd0, 8'd0);
    endtask

    // mode 0: random CPU slots; 1: none; 2: five CPU slots right after acceptance
    // (first one writes 0x5A to 0x20); 3: CPU read of byte lo+2 on the cycle after the LO issue.
    task automatic run_xfer(input bit wr, input logic [16:0] addr, input logic [15:0] din, input int mode);
        bit          sl [48];
        bit          cw [48];
        logic [16:0] ca [48];
        logic [7:0]  cd [48];
        int          a, b, c, ack, s0;
        logic [16:0] lo, hi;
        logic [7:0]  rlo, rhi;
        exp_t        e;
        for (int i = 0; i < 48; i++) begin
            sl[i] = (mode == 0 && i < 40) ? ($urandom_range(0, 2) == 0) : 1'b0;
            cw[i] = 1'($urandom_range(0, 1));
            ca[i] = rand_addr();
            cd[i] = 8'($urandom);
        end
        lo = {addr[16:1], 1'b0};
        hi = {addr[16:1], 1'b1};
        if (mode == 2) begin
            for (int i = 1; i <= 5; i++) begin
                sl[i] = 1'b1;
                cw[i] = (i == 1);
            end
            ca[1] = 17'h20;
            cd[1] = 8'h5A;
        end
        if (mode == 3) begin
            sl[2] = 1'b1;
            cw[2] = 1'b0;
            ca[2] = lo + 17'd2;
        end
        // Accept on the first free cycle, then each byte takes the next free cycle.
        a = 0;
        while (sl[a]) a++;
        b = a + 1;
        while (sl[b]) b++;
        c = b + 1;
        while (sl[c]) c++;
        ack = c + 2;
        rlo = 8'd0;
        rhi = 8'd0;
        for (int i = 0; i <= ack; i++) begin
            if (sl[i] && cw[i]) shadow[ca[i]] = cd[i];
            if (i == b) begin
                if (wr) shadow[lo] = din[7:0];
                else    rlo = shadow[lo];
            end
            if (i == c) begin
                if (wr) shadow[hi] = din[15:8];
                else    rhi = shadow[hi];
            end
        end
        s0     = cyc;
        e.cyc  = s0 + ack;
        e.rd   = !wr;
        e.word = {rhi, rlo};
        exp_q.push_back(e);
        for (int i = 0; i <= ack; i++) begin
            bk_if.bk_req = 1'b1;
            if (i <= a) begin
                bk_if.bk_wr   = wr;
                bk_if.bk_addr = addr;
                bk_if.bk_din  = din;
            end else begin
                bk_if.bk_wr   = 1'($urandom_range(0, 1));
                bk_if.bk_addr = 17'($urandom);
                bk_if.bk_din  = 16'($urandom);
            end
            step(sl[i], cw[i], ca[i], cd[i], (i == b) ? 0 : ((i == c) ? 1 : -1), wr,
                 (i == b) ? lo : hi, (i == b) ? din[7:0] : din[15:8]);
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset_n       = 1'b0;
        ce_cpu        = 1'b0;
        cpu_req       = 1'b0;
        cpu_wr        = 1'b0;
        cpu_addr      = '0;
        cpu_di        = '0;
        bk_if.bk_req  = 1'b0;
        bk_if.bk_wr   = 1'b0;
        bk_if.bk_addr = '0;
        bk_if.bk_din  = '0;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_busy", 32'(bk_if.busy), 32'd0);
        chk("rst_ack", 32'(bk_if.bk_ack), 32'd0);
        chk("rst_dout", 32'(bk_if.bk_dout), 32'd0);
        reset_n = 1'b1;
        @(posedge clk_sys);
        #1;

        for (int i = 0; i < 128; i++) cpu_write(17'(i), 8'($urandom));
        for (int i = 0; i < 128; i++) cpu_write(17'(17'h1FF80 + i), 8'($urandom));

        run_xfer(1'b1, 17'h00010, 16'hBEEF, 1);
        chk("wr_lo_byte", 32'(mem[17'h10]), 32'hEF);
        chk("wr_hi_byte", 32'(mem[17'h11]), 32'hBE);

        cpu_write(17'h1FFFE, 8'h34);
        cpu_write(17'h1FFFF, 8'h12);
        run_xfer(1'b0, 17'h1FFFF, 16'h0000, 1);
        chk("rd_dout_1234", 32'(bk_if.bk_dout), 32'h1234);

        run_xfer(1'b1, 17'h00030, 16'hC3A5, 2);
        chk("cpu_wr_5a", 32'(mem[17'h20]), 32'h5A);

        cpu_write(17'h40, 8'h11);
        cpu_write(17'h41, 8'h22);
        cpu_write(17'h42, 8'h77);
        run_xfer(1'b0, 17'h00040, 16'h0000, 3);

        run_xfer(1'b1, 17'h00050, 16'hA55A, 1);
        run_xfer(1'b0, 17'h00051, 16'h0000, 1);
        idle(3);

        // Abort in HI: the even byte is already in RAM, the odd byte must never be written.
        begin
            logic [7:0] old_hi;
            old_hi        = shadow[17'h61];
            bk_if.bk_req  = 1'b1;
            bk_if.bk_wr   = 1'b1;
            bk_if.bk_addr = 17'h00061;
            bk_if.bk_din  = 16'h9C3E;
            step(1'b0, 1'b0, 17'h0, 8'h0, -1, 1'b0, 17'd0, 8'd0);
            step(1'b0, 1'b0, 17'h0, 8'h0, 0, 1'b1, 17'h60, 8'h3E);
            set_cpu(1'b0, 1'b0, rand_addr(), 8'h00);
            #2;
            reset_n = 1'b0;
            bk_if.bk_req = 1'b0;
            #1;
            chk("abort_busy", 32'(bk_if.busy), 32'd0);
            chk("abort_ack", 32'(bk_if.bk_ack), 32'd0);
            chk("abort_dout", 32'(bk_if.bk_dout), 32'd0);
            repeat (2) @(posedge clk_sys);
            #1;
            reset_n = 1'b1;
            chk("abort_lo_kept", 32'(mem[17'h60]), 32'h3E);
            chk("abort_hi_untouched", 32'(mem[17'h61]), 32'(old_hi));
            shadow[17'h60] = 8'h3E;
            idle(8);
            chk("abort_idle_busy", 32'(bk_if.busy), 32'd0);
        end

        repeat (150) begin
            run_xfer(1'($urandom_range(0, 1)), rand_addr(), 16'($urandom), 0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        idle(5);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 128; i++) chk("mem_low", 32'(mem[i]), 32'(shadow[i]));
        for (int i = 17'h1FF80; i < 17'h20000; i++) chk("mem_high", 32'(mem[i]), 32'(shadow[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
